// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive front end:
// SYNC pattern, unstuffer state type and default limits.
package usb_rx_pkg;

   localparam logic [7:0] SYNC_IN      = 8'b0000_0001;
   localparam int         MAX_ONES_DEF = 6;
   localparam int         EOP_SE0_DEF  = 2;

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_DATA,
      ST_EOP,
      ST_ERROR
   } rx_state_t;

endpackage

// File: rtl/rx_sync_detect.sv
// SYNC hunter: 8-bit line shift register plus pattern match.
// Ports: clk/rst, clear (load all-ones), shift + bit_in (shift one
// line bit in), sync_hit (the register after this shift is SYNC).
module rx_sync_detect
   import usb_rx_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic shift,
   input  logic bit_in,
   output logic sync_hit
);

   logic [7:0] sr;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sr <= 8'hFF;
      end else if (shift) begin
         sr <= {sr[6:0], bit_in};
      end
   end

   // Looks at the value the register will hold after shifting,
   // so the match is known in the cycle of the final SYNC bit.
   assign sync_hit = ({sr[6:0], bit_in} == SYNC_IN);

endmodule

// File: rtl/rx_bit_unstuffer.sv
// Receive bit unstuffer: SYNC hunt, stuffed-zero removal, EOP detect.
// Inputs: clk, rst, abort, bit_en/nrzi_bit/se0 line bit, rc_stuff_error.
// Outputs: s_in/s_valid data, start_decode/end_decode framing pulses,
// rx_active packet level, stuff_error level until acknowledged.
module rx_bit_unstuffer
   import usb_rx_pkg::*;
#(
   parameter int MAX_ONES     = MAX_ONES_DEF,
   parameter int EOP_SE0_BITS = EOP_SE0_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic abort,
   input  logic bit_en,
   input  logic nrzi_bit,
   input  logic se0,
   input  logic rc_stuff_error,
   output logic s_in,
   output logic s_valid,
   output logic start_decode,
   output logic end_decode,
   output logic rx_active,
   output logic stuff_error
);

   localparam logic [2:0] ONES_LIM = 3'(MAX_ONES);
   localparam logic [1:0] SE0_LIM  = 2'(EOP_SE0_BITS);

   rx_state_t  state, state_n;
   logic [2:0] ones_cnt, ones_n;
   logic [1:0] se0_cnt, se0_n;
   logic       first, first_n;
   logic       act_n, valid_n, sin_n, start_n, end_n;
   logic       sr_shift, sr_clear, sync_hit;

   rx_sync_detect u_sync (
      .clk      (clk),
      .rst      (rst),
      .clear    (sr_clear | abort),
      .shift    (sr_shift),
      .bit_in   (nrzi_bit),
      .sync_hit (sync_hit)
   );

   always_comb begin
      state_n  = state;
      ones_n   = ones_cnt;
      se0_n    = se0_cnt;
      first_n  = first;
      act_n    = rx_active;
      valid_n  = 1'b0;
      sin_n    = 1'b0;
      start_n  = 1'b0;
      end_n    = 1'b0;
      sr_shift = 1'b0;
      sr_clear = 1'b0;
      // The acknowledge is honoured whether or not a bit is present.
      if (state == ST_ERROR && rc_stuff_error) begin
         state_n  = ST_HUNT;
         sr_clear = 1'b1;
      end else if (bit_en) begin
         unique case (state)
            ST_HUNT: begin
               if (se0) begin
                  sr_clear = 1'b1;
               end else begin
                  sr_shift = 1'b1;
                  if (sync_hit) begin
                     state_n = ST_DATA;
                     ones_n  = 3'd1;
                     first_n = 1'b1;
                     act_n   = 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (se0) begin
                  state_n = ST_EOP;
                  se0_n   = 2'd1;
               end else if (ones_cnt == ONES_LIM) begin
                  if (!nrzi_bit) begin
                     ones_n = 3'd0;
                  end else begin
                     state_n = ST_ERROR;
                     act_n   = 1'b0;
                  end
               end else begin
                  valid_n = 1'b1;
                  sin_n   = nrzi_bit;
                  start_n = first;
                  first_n = 1'b0;
                  ones_n  = nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
               end
            end
            ST_EOP: begin
               if (se0) begin
                  se0_n = se0_cnt + 2'd1;
                  if (se0_n == SE0_LIM) begin
                     // An empty packet ends silently; otherwise
                     // rx_active stays up through the end pulse.
                     end_n    = !first;
                     act_n    = !first;
                     state_n  = ST_HUNT;
                     sr_clear = 1'b1;
                  end
               end else begin
                  state_n = ST_ERROR;
                  act_n   = 1'b0;
               end
            end
            ST_ERROR: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_HUNT;
         ones_cnt     <= 3'd0;
         se0_cnt      <= 2'd0;
         first        <= 1'b0;
         s_in         <= 1'b0;
         s_valid      <= 1'b0;
         start_decode <= 1'b0;
         end_decode   <= 1'b0;
         rx_active    <= 1'b0;
         stuff_error  <= 1'b0;
      end else if (abort) begin
         state        <= ST_HUNT;
         s_in         <= 1'b0;
         s_valid      <= 1'b0;
         start_decode <= 1'b0;
         end_decode   <= 1'b0;
         rx_active    <= 1'b0;
         stuff_error  <= 1'b0;
      end else begin
         state        <= state_n;
         ones_cnt     <= ones_n;
         se0_cnt      <= se0_n;
         first        <= first_n;
         s_in         <= sin_n;
         s_valid      <= valid_n;
         start_decode <= start_n;
         end_decode   <= end_n;
         rx_active    <= end_decode ? 1'b0 : act_n;
         stuff_error  <= (state_n == ST_ERROR);
      end
   end

endmodule

// File: tb/tb_rx_bit_unstuffer.sv
// Bench for rx_bit_unstuffer: history-based reference model,
// per-cycle output compare, directed packets and random traffic.
module tb_rx_bit_unstuffer;

   localparam int MAXO = 6;
   localparam int NEOP = 2;
   localparam int M_HUNT = 0;
   localparam int M_PKT  = 1;
   localparam int M_EOP  = 2;
   localparam int M_ERR  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic abort = 1'b0;
   logic bit_en = 1'b0;
   logic nrzi_bit = 1'b0;
   logic se0 = 1'b0;
   logic rc_stuff_error = 1'b0;
   logic s_in, s_valid, start_decode, end_decode;
   logic rx_active, stuff_error;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   rx_bit_unstuffer dut (
      .clk            (clk),
      .rst            (rst),
      .abort          (abort),
      .bit_en         (bit_en),
      .nrzi_bit       (nrzi_bit),
      .se0            (se0),
      .s_in           (s_in),
      .s_valid        (s_valid),
      .start_decode   (start_decode),
      .end_decode     (end_decode),
      .rx_active      (rx_active),
      .stuff_error    (stuff_error),
      .rc_stuff_error (rc_stuff_error)
   );

   // Reference model: the last eight line bits while hunting, the
   // whole line history of the packet, and a delivered-bit count.
   int mode = M_HUNT;
   bit win[$];
   bit hist[$];
   int ndel = 0;
   int nse0 = 0;
   bit e_valid = 0, e_sin = 0, e_start = 0, e_end = 0;
   bit e_act = 0, e_err = 0;

   bit dq[$];
   bit mq[$];
   int dstarts = 0, dends = 0, mstarts = 0, mends = 0;
   bit checking = 0;
   int gap_lo = 0, gap_hi = 0;

   function automatic void fill_win();
      win.delete();
      repeat (8) win.push_back(1'b1);
   endfunction

   function automatic bit win_is_sync();
      for (int i = 0; i < 7; i++)
         if (win[i]) return 1'b0;
      return win[7];
   endfunction

   function automatic int trail_ones();
      int n = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (!hist[i]) break;
         n++;
      end
      return n;
   endfunction

   function automatic void model_step(bit r, bit en, bit b, bit s,
                                      bit ab, bit rc);
      bit prev_end = e_end;
      e_valid = 0; e_sin = 0; e_start = 0; e_end = 0;
      if (r || ab) begin
         mode = M_HUNT; fill_win(); e_act = 0; e_err = 0;
         return;
      end
      if (prev_end) e_act = 0;
      if (mode == M_ERR && rc) begin
         mode = M_HUNT; fill_win(); e_err = 0;
         return;
      end
      if (!en) return;
      case (mode)
         M_HUNT: begin
            if (s) fill_win();
            else begin
               win.push_back(b);
               void'(win.pop_front());
               if (win_is_sync()) begin
                  mode = M_PKT; hist.delete(); hist.push_back(1'b1);
                  ndel = 0; e_act = 1;
               end
            end
         end
         M_PKT: begin
            if (s) begin
               mode = M_EOP; nse0 = 1;
            end else if (trail_ones() >= MAXO) begin
               hist.push_back(b);
               if (b) begin
                  mode = M_ERR; e_err = 1; e_act = 0;
               end
            end else begin
               hist.push_back(b);
               e_valid = 1; e_sin = b; e_start = (ndel == 0);
               ndel++;
            end
         end
         M_EOP: begin
            if (s) begin
               nse0++;
               if (nse0 == NEOP) begin
                  e_end = (ndel > 0);
                  if (ndel == 0) e_act = 0;
                  mode = M_HUNT; fill_win();
               end
            end else begin
               mode = M_ERR; e_err = 1; e_act = 0;
            end
         end
         default: ;
      endcase
      if (e_valid) mq.push_back(e_sin);
      mstarts += int'(e_start);
      mends += int'(e_end);
   endfunction

   task automatic chk(string name, logic got, logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_int(string name, int got, int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic chkq(string name, bit got[$], bit exp[$]);
      int diff = -1;
      total++;
      if (got.size() == exp.size()) begin
         for (int i = 0; i < got.size(); i++)
            if (got[i] != exp[i] && diff < 0) diff = i;
      end else begin
         diff = 0;
      end
      if (diff >= 0) begin
         bad++;
         $display("FAIL %s got_len=%0d exp_len=%0d first_diff=%0d",
                  name, got.size(), exp.size(), diff);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("s_valid", s_valid, e_valid);
         chk("start_decode", start_decode, e_start);
         chk("end_decode", end_decode, e_end);
         chk("rx_active", rx_active, e_act);
         chk("stuff_error", stuff_error, e_err);
         if (e_valid) chk("s_in", s_in, e_sin);
      end
      if (s_valid === 1'b1) dq.push_back(s_in);
      if (start_decode === 1'b1) dstarts++;
      if (end_decode === 1'b1) dends++;
   end

   task automatic tick(bit en, bit b, bit s, bit ab, bit rc);
      bit_en = en; nrzi_bit = b; se0 = s;
      abort = ab; rc_stuff_error = rc;
      @(posedge clk);
      #1;
      model_step(rst, en, b, s, ab, rc);
      bit_en = 0; nrzi_bit = 0; se0 = 0;
      abort = 0; rc_stuff_error = 0;
   endtask

   task automatic lbit(bit b, bit s);
      int g = (gap_hi > 0) ? $urandom_range(gap_hi, gap_lo) : 0;
      repeat (g) tick(0, 0, 0, 0, 0);
      tick(1, b, s, 0, 0);
   endtask

   task automatic send_sync();
      repeat (7) lbit(0, 0);
      lbit(1, 0);
   endtask

   task automatic send_bits(bit q[$]);
      foreach (q[i]) lbit(q[i], 0);
   endtask

   task automatic send_eop();
      lbit(0, 1);
      lbit(0, 1);
   endtask

   task automatic idle();
      repeat (3) tick(0, 0, 0, 0, 0);
   endtask

   task automatic clr_obs();
      dq.delete(); mq.delete();
      dstarts = 0; dends = 0; mstarts = 0; mends = 0;
   endtask

   task automatic pkt_check(string name, bit lit[$], int st, int en);
      chkq({name, "_dut_bits"}, dq, lit);
      chkq({name, "_model_bits"}, mq, lit);
      chk_int({name, "_starts"}, dstarts, st);
      chk_int({name, "_ends"}, dends, en);
   endtask

   bit A5[$]    = '{1, 0, 1, 0, 0, 1, 0, 1};
   bit SLINE[$] = '{1, 1, 1, 1, 1, 0, 1, 0};
   bit SOUT[$]  = '{1, 1, 1, 1, 1, 1, 0};
   bit FIVE_A5[$] = '{1, 1, 1, 1, 1};
   bit NONE[$];

   initial begin
      fill_win();
      rst = 1'b1;
      tick(0, 0, 0, 0, 0);
      tick(1, 1, 0, 0, 0);
      rst = 1'b0;
      checking = 1'b1;
      chk("rst_s_valid", s_valid, 1'b0);
      chk("rst_rx_active", rx_active, 1'b0);
      chk("rst_stuff_error", stuff_error, 1'b0);
      chk("rst_end_decode", end_decode, 1'b0);
      idle();

      clr_obs();
      send_sync(); send_bits(A5); send_eop(); idle();
      pkt_check("basic", A5, 1, 1);
      chk("basic_act_low", rx_active, 1'b0);

      clr_obs();
      send_sync(); send_bits(SLINE); send_eop(); idle();
      pkt_check("stuffed", SOUT, 1, 1);

      clr_obs();
      send_sync();
      repeat (5) lbit(1, 0);
      chk("viol_before", stuff_error, 1'b0);
      lbit(1, 0);
      chk("viol_rise", stuff_error, 1'b1);
      repeat (10) lbit(1'($urandom % 2), 0);
      chk("viol_held", stuff_error, 1'b1);
      tick(0, 0, 0, 0, 1);
      chk("viol_ack", stuff_error, 1'b0);
      foreach (A5[i]) FIVE_A5.push_back(A5[i]);
      send_sync(); send_bits(A5); send_eop(); idle();
      pkt_check("viol_resync", FIVE_A5, 2, 1);

      clr_obs();
      send_sync(); lbit(1, 0); lbit(0, 0);
      lbit(0, 1); lbit(1, 0); idle();
      chk("frame_err", stuff_error, 1'b1);
      chk_int("frame_ends", dends, 0);
      tick(0, 0, 0, 0, 1); idle();

      clr_obs();
      send_sync(); lbit(1, 0); lbit(0, 0); lbit(1, 0);
      tick(0, 0, 0, 1, 0);
      chk("abort_act", rx_active, 1'b0);
      idle();
      chk_int("abort_ends", dends, 0);
      clr_obs();
      send_sync(); send_bits(A5); send_eop(); idle();
      pkt_check("after_abort", A5, 1, 1);

      clr_obs();
      send_sync(); send_eop(); idle();
      pkt_check("empty", NONE, 0, 0);
      chk("empty_act", rx_active, 1'b0);

      clr_obs();
      gap_lo = 1; gap_hi = 5;
      send_sync(); send_bits(A5); send_eop(); idle();
      pkt_check("gapped", A5, 1, 1);

      for (int p = 0; p < 200; p++) begin
         int r = $urandom_range(7, 0);
         gap_lo = 0;
         gap_hi = $urandom_range(2, 0);
         if (r <= 4) begin
            int n = $urandom_range(12, 0);
            if ($urandom_range(1, 0) == 1) tick(0, 0, 0, 0, 1);
            send_sync();
            for (int i = 0; i < n; i++) begin
               if ($urandom_range(40, 0) == 0) tick(0, 0, 0, 1, 0);
               lbit($urandom_range(3, 0) != 0, 0);
            end
            lbit(0, 1);
            if ($urandom_range(5, 0) != 0) lbit(0, 1);
            lbit(1, 0);
         end else if (r == 5) begin
            repeat ($urandom_range(6, 1))
               lbit(1'($urandom % 2), $urandom_range(7, 0) == 0);
         end else if (r == 6) begin
            tick(1'($urandom % 2), 1, 0, 0, 1);
         end else begin
            tick(1'($urandom % 2), 0, 0, 1, 0);
         end
      end
      idle();
      checking = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rx_bit_unstuffer.md
# rx_bit_unstuffer

Receive-path stage that sits directly upstream of the bitstream decoder. It consumes NRZI-decoded line bits, hunts for SYNC, removes stuffed zeros, and detects EOP. It delivers a valid-qualified unstuffed bit stream framed by `start_decode` and `end_decode` pulses. Stuffing and framing violations are reported to the protocol FSM, which acknowledges them.

## Interface

Reset is synchronous and active-high; the block uses one clock, `clk`, and reset `rst`.

Parameters:
- `MAX_ONES`, default 6: consecutive 1s after which a stuffed 0 is mandatory.
- `EOP_SE0_BITS`, default 2: consecutive SE0 bit times that form a valid EOP.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `abort` in 1: drop the current packet and return to HUNT.
- `bit_en` in 1: strobe marking that a line bit is present this cycle.
- `nrzi_bit` in 1: NRZI-decoded bit (1 = no transition), qualified by `bit_en`.
- `se0` in 1: line is SE0 during this bit, qualified by `bit_en`.
- `s_in` out 1: unstuffed data bit.
- `s_valid` out 1: `s_in` is valid this cycle (1-cycle pulse).
- `start_decode` out 1: pulse coincident with the first data bit (PID bit 0) after SYNC.
- `end_decode` out 1: pulse on valid EOP; `s_valid` is 0 in that cycle.
- `rx_active` out 1: high from SYNC match through the `end_decode` cycle.
- `stuff_error` out 1: level; stuffing or framing violation.
- `rc_stuff_error` in 1: protocol FSM acknowledge of `stuff_error`.

## Operation

- States: HUNT, DATA, EOP, ERROR. Registers: 8-bit shift register `sr`, 3-bit `ones_cnt`, 2-bit `se0_cnt`, 1-bit `first`.
- Only `bit_en` cycles advance state. With `bit_en` = 0, all pulses are 0 and all registers hold.
- **HUNT:**
  - Each non-SE0 bit updates `sr <= {sr[6:0], nrzi_bit}`. An SE0 bit loads `sr <= 8'hFF`.
  - When the next `sr` equals `SYNC_IN` (8'b0000_0001), go to DATA with `ones_cnt` = 1 (the SYNC's final 1 counts), `first` = 1, and set `rx_active`.
- **DATA**, evaluated in priority order:
  - `se0`: go to EOP, `se0_cnt` = 1.
  - `ones_cnt` == `MAX_ONES` and bit = 0: drop the bit (no `s_valid`), `ones_cnt` = 0.
  - `ones_cnt` == `MAX_ONES` and bit = 1: go to ERROR, set `stuff_error`, clear `rx_active`.
  - Otherwise: `s_valid` = 1, `s_in` = bit, `start_decode` = `first`, `first` = 0. `ones_cnt` becomes `ones_cnt`+1 if the bit is 1, else 0.
- **EOP:**
  - An `se0` bit increments `se0_cnt`. When it reaches `EOP_SE0_BITS`: if `first` = 0, pulse `end_decode`; in all cases clear `rx_active` and go to HUNT with `sr` = 8'hFF.
  - A non-SE0 bit before the count completes is a framing error: go to ERROR and set `stuff_error`.
- **SE0 directly after SYNC** (`first` still 1): no `start_decode`, no `end_decode`, return to HUNT silently.
- **ERROR:**
  - `stuff_error` is held at 1 and line bits are ignored.
  - On `rc_stuff_error`, `stuff_error` clears on the next clock and the state goes to HUNT with `sr` = 8'hFF.
- **`abort`:** overrides all states. Next state is HUNT, all outputs go to 0 (including `stuff_error`), and `sr` = 8'hFF. No `end_decode` is generated.
- **`rst`:** same as `abort`, and additionally clears all counters. It takes priority over `abort`.

## Timing

- All outputs are registered.
- `s_valid`, `s_in`, `start_decode` and `end_decode` assert exactly one clk after the qualifying `bit_en` cycle and last one clk.
- `stuff_error` rises one clk after the offending bit and falls one clk after the `rc_stuff_error` cycle.
- `rx_active` rises one clk after the final SYNC bit.
- Reset values: `s_in`, `s_valid`, `start_decode`, `end_decode`, `rx_active`, `stuff_error` all 0; state HUNT; `sr` = 8'hFF; `ones_cnt` = `se0_cnt` = 0; `first` = 0.
- Back-to-back `bit_en` (every cycle) is supported at full rate.

## Structure

- Shared package `usb_rx_pkg`: `SYNC_IN` constant, state enum type, `MAX_ONES` default.
- Sub-module `rx_sync_detect`: shift register plus SYNC match. It outputs `sync_hit` and accepts a `clear` input that loads 8'hFF. Stuffing, EOP and the FSM live in the top module.

## Test plan

- **Basic packet:** SYNC + bits 1,0,1,0,0,1,0,1 (0xA5) + 2 SE0 → 8 `s_valid` pulses carrying 1,0,1,0,0,1,0,1; `start_decode` on the first; `end_decode` one clk after the second SE0; `rx_active` low afterwards.
- **Stuffed zero removed:** SYNC + 1,1,1,1,1,0,1,0 → 7 `s_valid` pulses carrying 1,1,1,1,1,1,0; the sixth line bit is dropped.
- **Stuffing violation:** SYNC + six 1s → `stuff_error` = 1 one clk after the sixth 1 and held through 10 further bits; `rc_stuff_error` pulse → `stuff_error` = 0 the next clk; a following SYNC is detected.
- **Framing error:** single SE0 followed by a non-SE0 bit → `stuff_error` set, no `end_decode`.
- **Abort:** `abort` after the 3rd data bit → no `end_decode`, `rx_active` = 0 next clk; the next SYNC + 0xA5 decodes correctly. Also: SE0 immediately after SYNC → no pulses at all.
- **Gapped strobe:** `bit_en` at 1 in 4 cycles with random gaps → identical bit sequence to the basic packet; no outputs in non-strobe cycles.
